score_sequencer: RTL and testbench
==================================

# score_sequencer

Game-level controller that sequences the two-digit BCD score and lives counter feeding the scoreboard video generator. It arbitrates score and miss events from gameplay logic through req/ack handshakes and queues them in small pending counters. It commits at most one event per frame, at the start of vertical blanking, so digits never change mid-scan. A four-state game FSM covers attract, play, death pause and game over. It sits in the pixel-clock domain between the gameplay/collision logic and `scoreboard_generator`.

## Interface
- `START_LIVES`, 3: lives loaded at game start (1..9).
- `PEND_W`, 3: pending-counter width; max queued events per source = 2^PEND_W-1.
- `DEATH_FRAMES`, 60: frames spent in DYING (1..255).
- `clk` in 1: pixel clock.
- `reset` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the first vblank line.
- `start_btn` in 1: synchronised, debounced start level.
- `score_req` in 1: score event request; level, held until ack.
- `score_ack` out 1: one-cycle accept pulse for score_req.
- `miss_req` in 1: miss event request; level, held until ack.
- `miss_ack` out 1: one-cycle accept pulse for miss_req.
- `score0` out 4: BCD units digit.
- `score1` out 4: BCD tens digit.
- `lives` out 4: lives remaining (0..9).
- `state` out 2: 0 IDLE, 1 PLAY, 2 DYING, 3 OVER.
- `game_over` out 1: high when state==OVER.

## Operation
- Reset values: state=IDLE, score0=score1=0, lives=START_LIVES, acks=0, pending counters=0, death timer=0, game_over=0.
- Handshake per source:
  - A cycle with req=1, ack=0 and pending<max accepts the event.
  - The ack is registered and pulses the next cycle.
  - No acceptance occurs in a cycle where that ack is high, so a requester that drops req on seeing ack counts once.
  - When pending==max, req stalls with no ack until a commit frees a slot.
- Pending counters only accumulate in PLAY. In IDLE, DYING and OVER, requests are still acked but discarded, and both counters are held at 0.
- IDLE/OVER -> PLAY on start_btn=1:
  - Load score=00 and lives=START_LIVES.
  - Clear pending counters.
- PLAY, on frame_start, miss has priority:
  - If miss_pending>0: decrement it, lives-1 (saturating at 0), load death timer=DEATH_FRAMES, go to DYING. Score pending is discarded.
  - Else if score_pending>0: decrement it and BCD-increment the score. Units 9 -> 0 with a carry into tens. 99 saturates at 99.
- DYING: each frame_start decrements the timer. When it reaches 0, go to OVER if lives==0, else to PLAY.
- OVER holds the final score and lives until start_btn.
- Acceptance and commit in the same cycle on one source: the counter is unchanged.
- reset mid-game returns everything to its reset values immediately. Any ack in flight is lost, and requesters re-request.

## Timing
- Ack latency: 1 clk after the accepting edge.
- Commit: outputs update 1 clk after the frame_start cycle. At most one score or lives change per frame.
- State transitions on start_btn take effect 1 clk after it is sampled.
- DYING lasts exactly DEATH_FRAMES frame_start pulses.
- All outputs are registered with no combinational path from inputs.

## Configuration
- `SCORE_EXTRA_LIFE_EN` defined: a score commit whose result has score0==0 and score1==5 also increments lives, saturating at 9. This is the 49->50 crossing only; saturation at 99 awards nothing.
- Not defined: lives change only on miss and game start. No extra-life logic is synthesised.

## Structure
- Shared package `scoreboard_pkg`:
  - state encoding constants (IDLE/PLAY/DYING/OVER).
  - BCD digit width (4).
  - default START_LIVES.
  - blank-digit code 15.
- One sub-module, `event_pending_counter`, instantiated twice (score, miss). It owns the req/ack handshake, the saturating PEND_W counter, the consume input and the clear input.
- The FSM, BCD arithmetic and death timer live in the top module.

## Test plan
- Reset, start_btn pulse, 3 score reqs, 3 frame_starts -> 3 acks, score 03, lives 3, state PLAY.
- Score 09, one score req and one frame_start -> score0=0, score1=1. From 99, one more -> stays 99.
- 8 score reqs with no frame_start (PEND_W=3) -> 7 acks, 8th req stalls. The next frame_start commits one, and the stalled req is acked the following cycle.
- Score and miss pending together at frame_start -> lives 3->2, state DYING, score unchanged. After 60 frame_starts -> PLAY with score pending 0.
- Lives 1, miss committed, 60 frames -> state OVER, game_over=1. start_btn -> score 00, lives 3, PLAY.
- With `SCORE_EXTRA_LIFE_EN`, score 49, lives 2, one score commit -> score 50, lives 3. Without the macro -> lives 2.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: game state encoding, BCD digit type and defaults.
package scoreboard_pkg;

  localparam int unsigned BCD_W           = 4;
  localparam int unsigned START_LIVES_DEF = 3;
  localparam logic [BCD_W-1:0] BLANK_DIGIT = 4'd15;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

endpackage

// File: rtl/score_sequencer_if.sv
// Score/miss event request-acknowledge handshakes between gameplay logic and the sequencer.
interface score_sequencer_if;

  logic score_req;
  logic score_ack;
  logic miss_req;
  logic miss_ack;

  modport master (output score_req, output miss_req, input score_ack, input miss_ack);
  modport slave  (input score_req, input miss_req, output score_ack, output miss_ack);

endinterface

// File: rtl/event_pending_counter.sv
// One event source: req/ack handshake feeding a saturating pending-event counter.
module event_pending_counter #(
  parameter int unsigned PEND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              accum_en,
  input  logic              clear,
  input  logic              consume,
  output logic              ack,
  output logic [PEND_W-1:0] pending
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              ack_q, ack_d;
  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic              accept;

  always_comb begin
    // A high ack blocks acceptance so a requester dropping req on ack counts once.
    accept = req && !ack_q && (cnt_q != PEND_MAX);
    ack_d  = accept;
    cnt_d  = cnt_q;
    if (clear || !accum_en) begin
      cnt_d = '0;
    end else if (accept && !consume) begin
      cnt_d = cnt_q + 1'b1;
    end else if (consume && !accept && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      cnt_q <= cnt_d;
    end
  end

  assign ack     = ack_q;
  assign pending = cnt_q;

endmodule

// File: rtl/score_sequencer.sv
// Game FSM, BCD score and lives sequencing, committing at most one event per frame.
// Optional macro SCORE_EXTRA_LIFE_EN: award a life on the 49->50 score crossing.
module score_sequencer
  import scoreboard_pkg::*;
#(
  parameter int unsigned START_LIVES  = START_LIVES_DEF,
  parameter int unsigned PEND_W       = 3,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     start_btn,
  score_sequencer_if.slave         ev_if,
  output logic [BCD_W-1:0]         score0,
  output logic [BCD_W-1:0]         score1,
  output logic [BCD_W-1:0]         lives,
  output logic [1:0]               state,
  output logic                     game_over
);

  localparam bcd_t       LIVES_INIT = bcd_t'(START_LIVES);
  localparam logic [7:0] DEATH_INIT = 8'(DEATH_FRAMES);

  game_state_e       state_q, state_d;
  bcd_t              score0_q, score0_d;
  bcd_t              score1_q, score1_d;
  bcd_t              lives_q, lives_d;
  logic [7:0]        timer_q, timer_d;
  logic              game_over_q, game_over_d;

  logic [PEND_W-1:0] score_pend, miss_pend;
  logic              score_consume, miss_consume, pend_clear, accum_en;

  assign accum_en = (state_q == ST_PLAY);

  event_pending_counter #(.PEND_W(PEND_W)) u_score_pend (
    .clk      (clk),
    .reset    (reset),
    .req      (ev_if.score_req),
    .accum_en (accum_en),
    .clear    (pend_clear),
    .consume  (score_consume),
    .ack      (ev_if.score_ack),
    .pending  (score_pend)
  );

  event_pending_counter #(.PEND_W(PEND_W)) u_miss_pend (
    .clk      (clk),
    .reset    (reset),
    .req      (ev_if.miss_req),
    .accum_en (accum_en),
    .clear    (pend_clear),
    .consume  (miss_consume),
    .ack      (ev_if.miss_ack),
    .pending  (miss_pend)
  );

  always_comb begin
    state_d       = state_q;
    score0_d      = score0_q;
    score1_d      = score1_q;
    lives_d       = lives_q;
    timer_d       = timer_q;
    score_consume = 1'b0;
    miss_consume  = 1'b0;
    pend_clear    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_btn) begin
          state_d    = ST_PLAY;
          score0_d   = '0;
          score1_d   = '0;
          lives_d    = LIVES_INIT;
          pend_clear = 1'b1;
        end
      end
      ST_PLAY: begin
        if (frame_start) begin
          // Miss wins the frame; any queued score events are dropped with it.
          if (miss_pend != '0) begin
            miss_consume = 1'b1;
            pend_clear   = 1'b1;
            lives_d      = (lives_q == '0) ? '0 : lives_q - 1'b1;
            timer_d      = DEATH_INIT;
            state_d      = ST_DYING;
          end else if (score_pend != '0) begin
            score_consume = 1'b1;
            if (score0_q != 4'd9) begin
              score0_d = score0_q + 1'b1;
            end else if (score1_q != 4'd9) begin
              score0_d = '0;
              score1_d = score1_q + 1'b1;
            end
`ifdef SCORE_EXTRA_LIFE_EN
            if ((score0_d == '0) && (score1_d == 4'd5) && (lives_q != 4'd9)) begin
              lives_d = lives_q + 1'b1;
            end
`endif
          end
        end
      end
      ST_DYING: begin
        if (frame_start) begin
          timer_d = timer_q - 1'b1;
          if (timer_q <= 8'd1) begin
            timer_d = '0;
            state_d = (lives_q == '0) ? ST_OVER : ST_PLAY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      score0_q    <= '0;
      score1_q    <= '0;
      lives_q     <= LIVES_INIT;
      timer_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      game_over_q <= game_over_d;
    end
  end

  assign score0    = score0_q;
  assign score1    = score1_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer against an integer-level game model.
module tb_score_sequencer;

  localparam int SL   = 3;
  localparam int PMAX = 7;
  localparam int DF   = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       start_btn;
  logic [3:0] score0, score1, lives;
  logic [1:0] state;
  logic       game_over;

  score_sequencer_if ev_if ();

  score_sequencer #(
    .START_LIVES  (SL),
    .PEND_W       (3),
    .DEATH_FRAMES (DF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .start_btn   (start_btn),
    .ev_if       (ev_if.slave),
    .score0      (score0),
    .score1      (score1),
    .lives       (lives),
    .state       (state),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: score kept as a plain integer 0..99, states 0 idle,1 play,2 dying,3 over
  int m_state, m_score, m_lives, m_spend, m_mpend, m_timer;
  bit m_sack, m_mack;
  int want_s, want_m;
  int sack_seen, mack_seen;
  int l0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = SL;
    m_spend = 0; m_mpend = 0; m_timer = 0;
    m_sack = 1'b0; m_mack = 1'b0;
  endtask

  task automatic model_step(input bit fs, input bit sb, input bit sreq, input bit mreq);
    bit s_acc, m_acc;
    int sp, mp;
    s_acc = sreq && !m_sack && (m_spend < PMAX);
    m_acc = mreq && !m_mack && (m_mpend < PMAX);
    m_sack = s_acc;
    m_mack = m_acc;
    case (m_state)
      1: begin
        sp = m_spend + int'(s_acc);
        mp = m_mpend + int'(m_acc);
        if (fs && m_mpend > 0) begin
          if (m_lives > 0) m_lives--;
          m_timer = DF;
          m_state = 2;
          sp = 0; mp = 0;
        end else if (fs && m_spend > 0) begin
          sp--;
          if (m_score < 99) begin
            m_score++;
`ifdef SCORE_EXTRA_LIFE_EN
            if (m_score == 50 && m_lives < 9) m_lives++;
`endif
          end
        end
        m_spend = sp;
        m_mpend = mp;
      end
      2: begin
        m_spend = 0; m_mpend = 0;
        if (fs) begin
          m_timer--;
          if (m_timer == 0) m_state = (m_lives == 0) ? 3 : 1;
        end
      end
      default: begin
        m_spend = 0; m_mpend = 0;
        if (sb) begin
          m_state = 1; m_score = 0; m_lives = SL;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("score0", int'(score0), m_score % 10);
    check_eq("score1", int'(score1), m_score / 10);
    check_eq("lives", int'(lives), m_lives);
    check_eq("state", int'(state), m_state);
    check_eq("game_over", int'(game_over), int'(m_state == 3));
    check_eq("score_ack", int'(ev_if.score_ack), int'(m_sack));
    check_eq("miss_ack", int'(ev_if.miss_ack), int'(m_mack));
  endtask

  // Called at a negedge; drives one cycle of inputs, models the edge, checks, returns at next negedge.
  task automatic step(input bit fs, input bit sb);
    if (m_sack && want_s > 0) want_s--;
    if (m_mack && want_m > 0) want_m--;
    ev_if.score_req = (want_s > 0);
    ev_if.miss_req  = (want_m > 0);
    frame_start = fs;
    start_btn   = sb;
    @(posedge clk);
    model_step(fs, sb, ev_if.score_req, ev_if.miss_req);
    #1;
    check_all();
    if (ev_if.score_ack) sack_seen++;
    if (ev_if.miss_ack) mack_seen++;
    @(negedge clk);
  endtask

  task automatic add_scores(input int n);
    int k;
    while (n > 0) begin
      k = (n > 5) ? 5 : n;
      want_s += k;
      repeat (3 * k + 2) step(1'b0, 1'b0);
      repeat (k) step(1'b1, 1'b0);
      n -= k;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_start = 1'b0; start_btn = 1'b0;
    want_s = 0; want_m = 0;
    ev_if.score_req = 1'b0; ev_if.miss_req = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0; start_btn = 1'b0;
    ev_if.score_req = 1'b0; ev_if.miss_req = 1'b0;
    want_s = 0; want_m = 0; sack_seen = 0; mack_seen = 0;
    model_reset();
    @(negedge clk);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_lives", int'(lives), SL);
    check_eq("rst_score", int'({score1, score0}), 0);
    check_eq("rst_game_over", int'(game_over), 0);
    check_all();
    reset = 1'b0;

    // start, three scores, three frames
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_eq("start_play", int'(state), 1);
    sack_seen = 0;
    want_s = 3;
    repeat (11) step(1'b0, 1'b0);
    check_eq("three_acks", sack_seen, 3);
    repeat (3) step(1'b1, 1'b0);
    check_eq("score_03", int'({score1, score0}), 8'h03);
    check_eq("lives_3", int'(lives), 3);
    check_eq("still_play", int'(state), 1);

    // BCD carry, extra-life crossing, saturation at 99
    add_scores(6);
    check_eq("score_09", int'({score1, score0}), 8'h09);
    add_scores(1);
    check_eq("carry_units", int'(score0), 0);
    check_eq("carry_tens", int'(score1), 1);
    add_scores(39);
    check_eq("score_49", int'({score1, score0}), 8'h49);
    add_scores(1);
    check_eq("score_50", int'({score1, score0}), 8'h50);
`ifdef SCORE_EXTRA_LIFE_EN
    check_eq("extra_life", int'(lives), 4);
`else
    check_eq("no_extra_life", int'(lives), 3);
`endif
    add_scores(49);
    check_eq("score_99", int'({score1, score0}), 8'h99);
    add_scores(1);
    check_eq("score_99_sat", int'({score1, score0}), 8'h99);

    // pending saturation: 8 requests, 7 acks, stalled one released after a commit
    sack_seen = 0;
    want_s = 8;
    repeat (20) step(1'b0, 1'b0);
    check_eq("stall_acks", sack_seen, 7);
    check_eq("stall_no_ack", int'(ev_if.score_ack), 0);
    step(1'b1, 1'b0);
    check_eq("commit_frame_ack", int'(ev_if.score_ack), 0);
    step(1'b0, 1'b0);
    check_eq("stall_released", int'(ev_if.score_ack), 1);
    repeat (2) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);

    // score and miss pending together: miss wins
    l0 = m_lives;
    want_s = 1; want_m = 1;
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("miss_lives", int'(lives), l0 - 1);
    check_eq("miss_dying", int'(state), 2);
    check_eq("miss_score_kept", int'({score1, score0}), 8'h99);
    repeat (DF - 1) step(1'b1, 1'b0);
    check_eq("dying_held", int'(state), 2);
    step(1'b1, 1'b0);
    check_eq("dying_to_play", int'(state), 1);
    step(1'b1, 1'b0);

    // lose remaining lives, game over, restart
    for (int i = 0; i < 12 && m_lives > 1; i++) begin
      want_m = 1;
      repeat (4) step(1'b0, 1'b0);
      repeat (DF + 1) step(1'b1, 1'b0);
    end
    check_eq("lives_1", int'(lives), 1);
    want_m = 1;
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("lives_0", int'(lives), 0);
    repeat (DF) step(1'b1, 1'b0);
    check_eq("over_state", int'(state), 3);
    check_eq("over_flag", int'(game_over), 1);
    repeat (3) step(1'b1, 1'b0);
    check_eq("over_holds", int'(state), 3);
    step(1'b0, 1'b1);
    check_eq("restart_score", int'({score1, score0}), 0);
    check_eq("restart_lives", int'(lives), 3);
    check_eq("restart_play", int'(state), 1);

    // randomized play with a mid-game reset
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if (want_s == 0 && $urandom_range(0, 7) == 0) want_s = int'($urandom_range(1, 4));
      if (want_m == 0 && $urandom_range(0, 39) == 0) want_m = 1;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
